// File: rtl/fetch_queue_if.sv
// Bundle of fetch-stage signals: instruction-memory request/response, redirect,
// and the instruction stream toward decode. The master modport is the fetch stage.
interface fetch_queue_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_ready;

    modport master (
        output imem_req, imem_addr, inst_valid, inst, inst_pc,
        input  imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req, imem_addr, inst_valid, inst, inst_pc,
        output imem_ready, imem_rvalid, imem_rdata, redirect, redirect_pc, inst_ready
    );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch: owns the PC, keeps one memory read in flight and queues
// returned words with their PCs for decode; a redirect flushes and restarts.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.master bus
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       req_pc_q, req_pc_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [31:0]       mem_pc_q   [DEPTH];
    logic [31:0]       mem_inst_q [DEPTH];

    logic req_s;
    logic accept_s;
    logic push_s;
    logic pop_s;
    logic valid_s;

    // Requests are only issued with room left, so a response always fits even without a pop.
    assign valid_s  = (count_q != {CNT_W{1'b0}});
    assign req_s    = rst && !bus.redirect && (state_q == ST_IDLE) && (count_q < FULL_CNT);
    assign accept_s = req_s && bus.imem_ready;
    assign push_s   = (state_q == ST_WAIT) && bus.imem_rvalid && !bus.redirect;
    assign pop_s    = valid_s && bus.inst_ready && !bus.redirect;

    assign bus.imem_req   = req_s;
    assign bus.imem_addr  = pc_q;
    assign bus.inst_valid = valid_s;
    assign bus.inst       = mem_inst_q[rd_ptr_q];
    assign bus.inst_pc    = mem_pc_q[rd_ptr_q];

    // Next-state logic for PC, FSM and FIFO bookkeeping.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.redirect) begin
            pc_d     = bus.redirect_pc & 32'hFFFF_FFFC;
            count_d  = {CNT_W{1'b0}};
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_WAIT,
                ST_DROP: begin
                    if (bus.imem_rvalid) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DROP;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept_s) begin
                        req_pc_d = pc_q;
                        pc_d     = pc_q + 32'd4;
                        state_d  = ST_WAIT;
                    end else begin
                        state_d  = ST_IDLE;
                    end
                end
                ST_WAIT,
                ST_DROP: begin
                    if (bus.imem_rvalid) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = state_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                2'b01:   count_d = count_q - {{(CNT_W-1){1'b0}}, 1'b1};
                default: count_d = count_q;
            endcase
        end
    end

    // State registers and FIFO storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0000_0000;
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_pc_q[i]   <= 32'h0000_0000;
                mem_inst_q[i] <= 32'h0000_0000;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_s) begin
                mem_pc_q[wr_ptr_q]   <= req_pc_q;
                mem_inst_q[wr_ptr_q] <= bus.imem_rdata;
            end
        end
    end

endmodule
